therm2bin_encoder: RTL

//  Digital back end of the 15-level flash front end. Receives the 15

---
 rtl/therm2bin_encoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/therm2bin_encoder.sv
// Back end for a 15-level flash converter. It synchronises the comparator lines,
// repairs bubbles, encodes to binary, optionally averages, and delivers valid/ready results.
module therm2bin_encoder #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int ACC_LOG2   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] y_in,
  input  logic        sample_en,
  output logic [3:0]  code_out,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        bubble_err,
  output logic        overrun,
  input  logic        flags_clr
);

  localparam int ACC_W = 4 + ACC_LOG2;
  localparam int CNT_W = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [14:0] s1, s2, t, c;
  logic [16:0] t_ext;
  logic [3:0]  pop, e;
  logic        e_vld;
  logic        bubble_set, overrun_set, handshake;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             res_vld;
  logic [3:0]       res;

  // NOTE: every register below uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= y_in;
      s2 <= s1;
    end
  end

  assign t     = ACTIVE_LOW ? ~s2 : s2;
  // Below level 1 counts as tripped, above level 15 as not tripped.
  assign t_ext = {1'b0, t, 1'b1};

  always_comb begin
    c   = '0;
    pop = '0;
    for (int i = 0; i < 15; i++) begin
      c[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
      pop  = pop + 4'(c[i]);
    end
  end

  assign bubble_set = sample_en && (c != t);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e     <= '0;
      e_vld <= 1'b0;
    end else begin
      e_vld <= sample_en;
      if (sample_en) e <= pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign acc_sum = acc + ACC_W'(e);
  assign res     = acc_sum[ACC_LOG2 +: 4];

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    res_vld   = 1'b0;
    if (e_vld) begin
      if (cnt == CNT_LAST) begin
        res_vld   = 1'b1;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = sample_en ? RUN : IDLE;
      end else begin
        acc_nxt   = acc_sum;
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = RUN;
      end
    end
  end

  assign handshake   = code_valid && code_ready;
  assign overrun_set = res_vld && code_valid && !code_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out   <= '0;
      code_valid <= 1'b0;
    end else if (res_vld && (!code_valid || code_ready)) begin
      code_out   <= res;
      code_valid <= 1'b1;
    end else if (handshake) begin
      code_valid <= 1'b0;
    end
  end

  // A flag event in the same cycle as flags_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (bubble_set)     bubble_err <= 1'b1;
      else if (flags_clr) bubble_err <= 1'b0;
      if (overrun_set)    overrun    <= 1'b1;
      else if (flags_clr) overrun    <= 1'b0;
    end
  end

endmodule
